core_timer_responder: RTL and testbench

Memory-mapped timer peripheral that acts as the responder on the core's data-port start/ready protocol. It is the slave end of the interface that mar810 drives as initiator: word address, write flag, write data, byte enables, start strobe, and ready/read-data return. It decodes a 4-word register window, services reads and writes with a fixed, parameterised latency, and runs a prescaled 32-bit counter with compare match. On a match it drives the core's irq input.

---
 rtl/core_timer_responder.sv | 136 +++++++++++++
 tb/tb_core_timer_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/core_timer_responder.sv
// core_timer_responder: memory-mapped prescaled compare timer on the start/ready data port
module core_timer_responder #(
    parameter logic [29:0] BASE     = 30'h0000_4000,
    parameter int          LATENCY  = 1,
    parameter int          PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [29:0] addr,
    input  logic        write,
    input  logic [31:0] data_wr,
    input  logic [3:0]  data_be,
    output logic        ready,
    output logic [31:0] data_rd,
    output logic        irq
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_RESP  = 2'd2;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [1:0]  state;
    logic [3:0]  wcnt;
    logic [29:0] req_addr;
    logic        req_write;
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic [2:0]  ctrl;
    logic [31:0] count;
    logic [31:0] compare;
    logic        pending;
    logic [15:0] pre;
    logic [29:0] off;
    logic        in_win;
    logic [31:0] reg_val;
    logic [31:0] merged;
    logic        wr_en;
    logic        tick;
    logic        match;

    // Decode the captured request, build read data and the byte-merged write value
    always_comb begin
        off     = req_addr - BASE;
        in_win  = (off[29:2] == 28'd0);
        reg_val = (off[1:0] == 2'd0) ? {29'd0, ctrl} :
                  (off[1:0] == 2'd1) ? count :
                  (off[1:0] == 2'd2) ? compare : {31'd0, pending};
        merged  = reg_val;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = req_be[i] ? req_data[8*i +: 8] : reg_val[8*i +: 8];
        ready   = (state == S_RESP);
        wr_en   = ready && req_write && in_win;
        tick    = ctrl[0] && (pre == PRE_MAX);
        match   = (count == compare);
        data_rd = (ready && in_win) ? reg_val : 32'd0;
    end

    // Request sequencer: capture on start, wait out the latency, pulse ready once
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            req_addr  <= 30'd0;
            req_write <= 1'b0;
            req_data  <= 32'd0;
            req_be    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    req_addr  <= addr;
                    req_write <= write;
                    req_data  <= data_wr;
                    req_be    <= data_be;
                    wcnt      <= LAT_M1;
                    state     <= (LATENCY == 1) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    wcnt  <= wcnt - 4'd1;
                    state <= (wcnt == 4'd1) ? S_RESP : S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Prescaler runs only while enabled and wraps on each tick
    always_ff @(posedge clk) begin
        if (rst || !ctrl[0])
            pre <= 16'd0;
        else
            pre <= tick ? 16'd0 : pre + 16'd1;
    end

    // Control register and compare value; writes land at the end of the response cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= 3'd0;
            compare <= 32'd0;
        end else begin
            if (wr_en && off[1:0] == 2'd0)
                ctrl <= merged[2:0];
            if (wr_en && off[1:0] == 2'd2)
                compare <= merged;
        end
    end

    // Counter: a bus write takes priority over a tick; match against the current compare
    always_ff @(posedge clk) begin
        if (rst)
            count <= 32'd0;
        else if (wr_en && off[1:0] == 2'd1)
            count <= merged;
        else if (tick)
            count <= (match && ctrl[1]) ? 32'd0 : count + 32'd1;
    end

    // Pending flag: a new match beats a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (rst)
            pending <= 1'b0;
        else if (tick && match)
            pending <= 1'b1;
        else if (wr_en && off[1:0] == 2'd3 && req_be[0] && req_data[0])
            pending <= 1'b0;
    end

    // Registered interrupt level
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= pending & ctrl[2];
    end
endmodule

// File: tb/tb_core_timer_responder.sv
// tb_core_timer_responder: randomized and directed checks of the timer responder
module tb_core_timer_responder;
    localparam logic [29:0] BASE = 30'h0000_4000;

    logic        clk = 0, rst = 0, start = 0, write = 0, sel = 0;
    logic [29:0] addr = 0;
    logic [31:0] data_wr = 0;
    logic [3:0]  data_be = 0;
    logic        ready_a, ready_b, irq_a, irq_b, start_a, start_b, rdy, irq;
    logic [31:0] data_rd_a, data_rd_b, drd;
    int tests_run = 0, tests_failed = 0, leaks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign rdy = sel ? ready_b : ready_a;
    assign drd = sel ? data_rd_b : data_rd_a;
    assign irq = sel ? irq_b : irq_a;

    core_timer_responder #(.BASE(BASE), .LATENCY(3), .PRESCALE(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .addr(addr), .write(write),
        .data_wr(data_wr), .data_be(data_be), .ready(ready_a), .data_rd(data_rd_a), .irq(irq_a));

    core_timer_responder #(.BASE(BASE), .LATENCY(1), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .addr(addr), .write(write),
        .data_wr(data_wr), .data_be(data_be), .ready(ready_b), .data_rd(data_rd_b), .irq(irq_b));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk); rst = 1; start = 0;
        @(negedge clk); rst = 0;
    endtask

    task automatic xfer(input logic s, input logic w, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output int lat);
        @(negedge clk); sel = s; start = 1; write = w; addr = a; data_wr = d; data_be = be;
        @(negedge clk); start = 0; lat = 1;
        while (!rdy && lat < 40) begin
            if (drd !== 32'd0) leaks++;
            @(negedge clk); lat++;
        end
        rd = drd;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat;
        sel = 0; do_reset(); leaks = 0;
        tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", rdy); end
        tests_run++; if (drd !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", drd); end
        tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", irq); end
        xfer(0, 0, BASE + 3, 0, 0, rd, lat);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL reset_lat: got %0d want 3", lat); end
        tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_status: got %h want 0", rd); end
        @(negedge clk);
        tests_run++; if (rdy !== 1'b0 || drd !== 32'd0) begin tests_failed++; $display("FAIL ready_single: got %b/%h want 0/0", rdy, drd); end
        tests_run++; if (leaks !== 0) begin tests_failed++; $display("FAIL data_idle: got %0d nonzero cycles want 0", leaks); end
    endtask

    task automatic test_byte_en();
        logic [31:0] rd; int lat;
        do_reset();
        xfer(0, 1, BASE + 1, 32'h1234_5678, 4'b0101, rd, lat);
        xfer(0, 0, BASE + 1, 0, 0, rd, lat);
        tests_run++; if (rd !== 32'h0034_0078) begin tests_failed++; $display("FAIL byte_en: got %h want 00340078", rd); end
        xfer(0, 1, BASE, 32'hFFFF_FFF8, 4'hF, rd, lat);
        xfer(0, 0, BASE, 0, 0, rd, lat);
        tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("FAIL ctrl_high_bits: got %h want 0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] m [4];
        logic [31:0] rd, d, nv, exp;
        logic [29:0] a;
        logic [3:0] be;
        logic w, inw;
        int lat, r, idx;
        do_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 6);
            a = (r < 6) ? BASE + 30'(r) : BASE - 30'd1;
            inw = (r < 4);
            idx = r & 3;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            be = 4'($urandom_range(0, 15));
            if (inw && idx == 0) d[0] = 1'b0;
            exp = inw ? m[idx] : 32'd0;
            xfer(0, w, a, d, be, rd, lat);
            tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL rand_lat: got %0d want 3", lat); end
            if (!w) begin
                tests_run++; if (rd !== exp) begin tests_failed++; $display("FAIL rand_read off %0d: got %h want %h", r, rd, exp); end
            end else if (inw && idx != 3) begin
                nv = m[idx];
                for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = d[8*b +: 8];
                m[idx] = (idx == 0) ? (nv & 32'h7) : nv;
            end
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] rd; int lat, c0, wc, t, nxt;
        do_reset();
        xfer(0, 1, BASE + 2, 32'd2, 4'hF, rd, lat);
        xfer(0, 1, BASE, 32'd7, 4'hF, rd, lat);
        c0 = cyc + 1;
        while (!irq && cyc < c0 + 100) @(negedge clk);
        tests_run++; if (cyc - c0 !== 4 * 3 + 1) begin tests_failed++; $display("FAIL irq_first: got %0d want %0d", cyc - c0, 13); end
        xfer(0, 0, BASE + 1, 0, 0, rd, lat);
        t = cyc - c0;
        tests_run++; if (rd !== 32'((t / 4) % 3)) begin tests_failed++; $display("FAIL reload_count: got %h want %h", rd, (t / 4) % 3); end
        xfer(0, 1, BASE + 3, 32'd1, 4'b0001, rd, lat);
        wc = cyc + 1;
        while (irq && cyc < wc + 50) @(negedge clk);
        tests_run++; if (cyc !== wc + 1) begin tests_failed++; $display("FAIL irq_clear: got %0d want %0d", cyc - c0, wc + 1 - c0); end
        nxt = ((wc - c0) / 12 + 1) * 12 + 1;
        while (!irq && cyc < c0 + 200) @(negedge clk);
        tests_run++; if (cyc - c0 !== nxt) begin tests_failed++; $display("FAIL irq_second: got %0d want %0d", cyc - c0, nxt); end
        xfer(0, 0, BASE + 3, 0, 0, rd, lat);
        tests_run++; if (rd !== 32'd1) begin tests_failed++; $display("FAIL status_pending: got %h want 1", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, exp; int lat, c0, t;
        do_reset();
        xfer(1, 1, BASE + 2, 32'd5, 4'hF, rd, lat);
        xfer(1, 1, BASE + 1, 32'hFFFF_FFFE, 4'hF, rd, lat);
        xfer(1, 1, BASE, 32'd1, 4'hF, rd, lat);
        c0 = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            xfer(1, 0, (i % 2 == 0) ? BASE + 1 : BASE + 3, 0, 0, rd, lat);
            t = cyc - c0;
            exp = (i % 2 == 0) ? 32'hFFFF_FFFE + 32'(t) : {31'd0, t >= 8};
            tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL wrap_lat: got %0d want 1", lat); end
            tests_run++; if (rd !== exp) begin tests_failed++; $display("FAIL wrap_read %0d t=%0d: got %h want %h", i, t, rd, exp); end
        end
        tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL wrap_irq: got %b want 0", irq); end
        sel = 0;
    endtask

    task automatic test_protocol();
        logic [31:0] rd, got; int lat, n, first;
        do_reset();
        xfer(0, 1, BASE + 1, 32'hAAAA_5555, 4'hF, rd, lat);
        xfer(0, 1, BASE + 2, 32'h0000_1234, 4'hF, rd, lat);
        @(negedge clk); start = 1; write = 0; addr = BASE + 1;
        n = 0; first = 0; got = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rdy) begin n++; if (first == 0) begin first = k; got = drd; end end
            start = (k == 1); addr = BASE + 2;
        end
        tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL ignore_start: got %0d readies want 1", n); end
        tests_run++; if (first !== 3) begin tests_failed++; $display("FAIL ignore_lat: got %0d want 3", first); end
        tests_run++; if (got !== 32'hAAAA_5555) begin tests_failed++; $display("FAIL ignore_data: got %h want aaaa5555", got); end
        xfer(0, 0, BASE + 8, 0, 0, rd, lat);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL oow_lat: got %0d want 3", lat); end
        tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("FAIL oow_read: got %h want 0", rd); end
        xfer(0, 1, BASE + 4, 32'hDEAD_BEEF, 4'hF, rd, lat);
        xfer(0, 0, BASE + 1, 0, 0, rd, lat);
        tests_run++; if (rd !== 32'hAAAA_5555) begin tests_failed++; $display("FAIL oow_write: got %h want aaaa5555", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat, n;
        do_reset();
        xfer(0, 1, BASE + 2, 32'd0, 4'hF, rd, lat);
        xfer(0, 1, BASE, 32'd7, 4'hF, rd, lat);
        n = 0;
        while (!irq && n < 50) begin @(negedge clk); n++; end
        tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL mid_irq_set: got %b want 1", irq); end
        @(negedge clk); start = 1; write = 0; addr = BASE + 1;
        @(negedge clk); start = 0; rst = 1;
        @(negedge clk); rst = 0;
        tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL mid_irq_clr: got %b want 0", irq); end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (rdy) n++;
            @(negedge clk);
        end
        tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL mid_no_ready: got %0d want 0", n); end
        for (int r = 0; r < 4; r++) begin
            xfer(0, 0, BASE + 30'(r), 0, 0, rd, lat);
            tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("FAIL mid_reg%0d: got %h want 0", r, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_en();
        test_random();
        test_timer_irq();
        test_wrap();
        test_protocol();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
